// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
//
// Bundles the pattern-pair handshake and the multiplexed display bus of
// seg_scan_driver.
//
// Signals:
//   segmentDigit1  [6:0]  tens pattern (abcdefg, a = MSB, active high)
//   segmentDigit2  [6:0]  ones pattern (abcdefg, a = MSB, active high)
//   in_valid              pattern pair on the digit inputs is valid
//   in_ready              pending buffer empty; pair accepted on valid&&ready
//   seg_out        [6:0]  shared segment bus, same bit order as the inputs
//   an             [1:0]  digit enables, active high; [1] tens, [0] ones
//   frame_done            one-cycle pulse at the start of each wrapped frame
//
// Modports:
//   master - the pattern source / display consumer (drives the digit inputs)
//   slave  - the scan driver itself
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic [6:0] segmentDigit1;
    logic [6:0] segmentDigit2;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] seg_out;
    logic [1:0] an;
    logic       frame_done;

    modport master (
        output segmentDigit1, segmentDigit2, in_valid,
        input  in_ready, seg_out, an, frame_done
    );

    modport slave (
        input  segmentDigit1, segmentDigit2, in_valid,
        output in_ready, seg_out, an, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexes two decoded 7-segment digit patterns onto one shared
// segment bus with per-digit anode enables and optional dead-time blanking
// between digits. A new pattern pair enters through a one-entry valid/ready
// buffer and is promoted to the displayed ("active") pair only at a frame
// boundary, so no frame ever shows a torn value.
//
// Scan order: SHOW_D1 -> BLANK1 -> SHOW_D2 -> BLANK2 -> SHOW_D1
//             (SHOW_D1 -> SHOW_D2 -> SHOW_D1 when BLANK_CYCLES == 0)
//
// Parameters:
//   CLK_DIV       cycles each digit is driven per frame (>= 1)
//   BLANK_CYCLES  dead-time cycles after each digit (0 removes blank states)
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   seg_scan_driver_if.slave (digit inputs, handshake, display outputs)
//
// Optional feature (compile-time macro SEG_LEADING_ZERO_BLANK_EN):
//   When defined, a tens digit showing "0" (7'b1111110) is suppressed: the
//   SHOW_D1 slot drives an=2'b00 and seg_out=0. The ones digit is never
//   suppressed. When undefined, the tens digit is always shown as received.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);

    // Counter must reach max(CLK_DIV, BLANK_CYCLES)-1; keep at least one bit.
    localparam int MAX_SLOT   = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_SLOT > 1) ? $clog2(MAX_SLOT) : 1;
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [CNT_W-1:0] SHOW_TC  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_LAST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [6:0] SEG_ZERO  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        SHOW_D1 = 2'd0,
        BLANK1  = 2'd1,
        SHOW_D2 = 2'd2,
        BLANK2  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       act1_q, act1_d;
    logic [6:0]       act2_q, act2_d;
    logic [6:0]       pend1_q, pend1_d;
    logic [6:0]       pend2_q, pend2_d;
    logic             pend_full_q, pend_full_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;
    logic             boundary;

    // -------------------------------------------------------------------------
    // Next-state, buffering and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        boundary     = 1'b0;
        act1_d       = act1_q;
        act2_d       = act2_q;
        pend1_d      = pend1_q;
        pend2_d      = pend2_q;
        pend_full_d  = pend_full_q;
        seg_d        = SEG_BLANK;
        an_d         = 2'b00;

        case (state_q)
            SHOW_D1: begin
                if (cnt_q == SHOW_TC) begin
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES > 0) ? BLANK1 : SHOW_D2;
                end
            end
            BLANK1: begin
                if (cnt_q == BLANK_TC) begin
                    cnt_d   = '0;
                    state_d = SHOW_D2;
                end
            end
            SHOW_D2: begin
                if (cnt_q == SHOW_TC) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = BLANK2;
                    end else begin
                        state_d  = SHOW_D1;
                        boundary = 1'b1;
                    end
                end
            end
            BLANK2: begin
                if (cnt_q == BLANK_TC) begin
                    cnt_d    = '0;
                    state_d  = SHOW_D1;
                    boundary = 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SHOW_D1;
            end
        endcase

        // Accept and promote are mutually exclusive: accept needs an empty
        // buffer, promote needs a full one. No bypass into the active pair.
        if (bus.in_valid && !pend_full_q) begin
            pend1_d     = bus.segmentDigit1;
            pend2_d     = bus.segmentDigit2;
            pend_full_d = 1'b1;
        end else if (boundary && pend_full_q) begin
            act1_d      = pend1_q;
            act2_d      = pend2_q;
            pend_full_d = 1'b0;
        end

        // Outputs are decoded from the *next* state and pair so the registered
        // values line up with the cycle the state is entered.
        case (state_d)
            SHOW_D1: begin
                an_d  = 2'b10;
                seg_d = act1_d;
`ifdef SEG_LEADING_ZERO_BLANK_EN
                if (act1_d == SEG_ZERO) begin
                    an_d  = 2'b00;
                    seg_d = SEG_BLANK;
                end
`endif
            end
            SHOW_D2: begin
                an_d  = 2'b01;
                seg_d = act2_d;
            end
            default: begin
                an_d  = 2'b00;
                seg_d = SEG_BLANK;
            end
        endcase

        frame_done_d = boundary;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SHOW_D1;
            cnt_q        <= '0;
            act1_q       <= SEG_BLANK;
            act2_q       <= SEG_BLANK;
            // NOTE: the pattern buffers are reset too, so a reset discards any stale pending pair.
            pend1_q      <= '0;
            pend2_q      <= '0;
            pend_full_q  <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= 2'b10;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act1_q       <= act1_d;
            act2_q       <= act2_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            pend_full_q  <= pend_full_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.in_ready   = !pend_full_q;
    assign bus.seg_out    = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Directed bench for seg_scan_driver. dut_a uses CLK_DIV=4, BLANK_CYCLES=1
// (frame of 10 cycles); dut_b uses CLK_DIV=3, BLANK_CYCLES=0 (frame of 6).
// Expected an/seg_out/frame_done come from a small frame-position model driven
// by a cycle counter that is zero in the first cycle after reset.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam logic [6:0] D0 = 7'b1111110;
    localparam logic [6:0] D1 = 7'b0110000;
    localparam logic [6:0] D2 = 7'b1101101;
    localparam logic [6:0] D3 = 7'b1111001;
    localparam logic [6:0] D4 = 7'b0110011;
    localparam logic [6:0] D5 = 7'b1011011;
    localparam logic [6:0] D6 = 7'b1011111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_driver_if bus_a ();
    seg_scan_driver_if bus_b ();

    seg_scan_driver #(.CLK_DIV(4), .BLANK_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    seg_scan_driver #(.CLK_DIV(3), .BLANK_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [6:0] e1, e2;      // expected active pair of the DUT under test
    logic [1:0] ea;
    logic [6:0] es;
    logic       ef;
    logic       er;

    // ---- reference model -----------------------------------------------------
    function automatic logic lz(logic [6:0] a1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (a1 == 7'b1111110);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [1:0] exp_an(int c, int cd, int bc, logic [6:0] a1);
        int p = c % (2 * (cd + bc));
        if (p < cd)          return lz(a1) ? 2'b00 : 2'b10;
        if (p < cd + bc)     return 2'b00;
        if (p < 2 * cd + bc) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] exp_seg(int c, int cd, int bc, logic [6:0] a1, logic [6:0] a2);
        int p = c % (2 * (cd + bc));
        if (p < cd)          return lz(a1) ? 7'b0 : a1;
        if (p < cd + bc)     return 7'b0;
        if (p < 2 * cd + bc) return a2;
        return 7'b0;
    endfunction

    // ---- stimulus helpers (no comparisons) ----------------------------------
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        e1  = '0;
        e2  = '0;
    endtask

    task automatic drive_a(logic v, logic [6:0] d1, logic [6:0] d2);
        bus_a.in_valid      = v;
        bus_a.segmentDigit1 = d1;
        bus_a.segmentDigit2 = d2;
    endtask

    // ---- scenarios ----------------------------------------------------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_a.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", bus_a.in_ready);
        end
        for (int i = 0; i < 30; i++) begin
            ea = exp_an(cyc, 4, 1, e1);
            es = exp_seg(cyc, 4, 1, e1, e2);
            ef = (cyc > 0) && (cyc % 10 == 0);
            checks += 3;
            if (bus_a.an !== ea) begin
                errors++;
                $display("FAIL reset_an cyc=%0d got=%b exp=%b", cyc, bus_a.an, ea);
            end
            if (bus_a.seg_out !== es) begin
                errors++;
                $display("FAIL reset_seg cyc=%0d got=%b exp=%b", cyc, bus_a.seg_out, es);
            end
            if (bus_a.frame_done !== ef) begin
                errors++;
                $display("FAIL reset_frame_done cyc=%0d got=%b exp=%b", cyc, bus_a.frame_done, ef);
            end
            step();
        end
    endtask

    // Entered at cyc 30 (frame start); 56 is accepted mid-frame at cyc 32.
    task automatic test_load();
        while (cyc < 50) begin
            if (cyc == 32) drive_a(1'b1, D5, D6);
            if (cyc == 33) drive_a(1'b0, '0, '0);
            if (cyc == 40) begin e1 = D5; e2 = D6; end
            ea = exp_an(cyc, 4, 1, e1);
            es = exp_seg(cyc, 4, 1, e1, e2);
            ef = (cyc % 10 == 0);
            er = !(cyc >= 33 && cyc < 40);
            checks += 4;
            if (bus_a.an !== ea) begin
                errors++;
                $display("FAIL load_an cyc=%0d got=%b exp=%b", cyc, bus_a.an, ea);
            end
            if (bus_a.seg_out !== es) begin
                errors++;
                $display("FAIL load_seg cyc=%0d got=%b exp=%b", cyc, bus_a.seg_out, es);
            end
            if (bus_a.frame_done !== ef) begin
                errors++;
                $display("FAIL load_frame_done cyc=%0d got=%b exp=%b", cyc, bus_a.frame_done, ef);
            end
            if (bus_a.in_ready !== er) begin
                errors++;
                $display("FAIL load_in_ready cyc=%0d got=%b exp=%b", cyc, bus_a.in_ready, er);
            end
            step();
        end
    endtask

    // Pair A accepted at cyc 52, pair B held valid from cyc 53 until accepted
    // right after A's promotion (end of cyc 60), then shown from cyc 70.
    task automatic test_back_to_back();
        while (cyc < 80) begin
            if (cyc == 52) drive_a(1'b1, D1, D2);
            if (cyc == 53) drive_a(1'b1, D3, D4);
            if (cyc == 61) drive_a(1'b0, '0, '0);
            if (cyc == 60) begin e1 = D1; e2 = D2; end
            if (cyc == 70) begin e1 = D3; e2 = D4; end
            ea = exp_an(cyc, 4, 1, e1);
            es = exp_seg(cyc, 4, 1, e1, e2);
            er = !((cyc >= 53 && cyc < 60) || (cyc >= 61 && cyc < 70));
            checks += 3;
            if (bus_a.an !== ea) begin
                errors++;
                $display("FAIL b2b_an cyc=%0d got=%b exp=%b", cyc, bus_a.an, ea);
            end
            if (bus_a.seg_out !== es) begin
                errors++;
                $display("FAIL b2b_seg cyc=%0d got=%b exp=%b", cyc, bus_a.seg_out, es);
            end
            if (bus_a.in_ready !== er) begin
                errors++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus_a.in_ready, er);
            end
            step();
        end
    endtask

    // 56 shown from cyc 90, another pair left pending at cyc 93, reset during
    // SHOW_D2 at cyc 95: both active and pending must be gone afterwards.
    task automatic test_reset_mid_frame();
        while (cyc < 95) begin
            if (cyc == 82) drive_a(1'b1, D5, D6);
            if (cyc == 83) drive_a(1'b0, '0, '0);
            if (cyc == 93) drive_a(1'b1, D1, D2);
            if (cyc == 94) drive_a(1'b0, '0, '0);
            step();
        end
        checks += 3;
        if (bus_a.an !== 2'b01) begin
            errors++;
            $display("FAIL pre_rst_an got=%b exp=01", bus_a.an);
        end
        if (bus_a.seg_out !== D6) begin
            errors++;
            $display("FAIL pre_rst_seg got=%b exp=%b", bus_a.seg_out, D6);
        end
        if (bus_a.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_rst_in_ready got=%b exp=0", bus_a.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        e1  = '0;
        e2  = '0;
        for (int i = 0; i < 25; i++) begin
            ea = exp_an(cyc, 4, 1, e1);
            ef = (cyc > 0) && (cyc % 10 == 0);
            checks += 4;
            if (bus_a.an !== ea) begin
                errors++;
                $display("FAIL mid_rst_an cyc=%0d got=%b exp=%b", cyc, bus_a.an, ea);
            end
            if (bus_a.seg_out !== 7'b0) begin
                errors++;
                $display("FAIL mid_rst_seg cyc=%0d got=%b exp=0000000", cyc, bus_a.seg_out);
            end
            if (bus_a.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_rst_in_ready cyc=%0d got=%b exp=1", cyc, bus_a.in_ready);
            end
            if (bus_a.frame_done !== ef) begin
                errors++;
                $display("FAIL mid_rst_frame_done cyc=%0d got=%b exp=%b", cyc, bus_a.frame_done, ef);
            end
            step();
        end
    endtask

    // dut_b: no blank states; 56 accepted at cyc 1, promoted at end of cyc 5.
    task automatic test_no_blank();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (cyc == 1) begin
                bus_b.in_valid      = 1'b1;
                bus_b.segmentDigit1 = D5;
                bus_b.segmentDigit2 = D6;
            end
            if (cyc == 2) bus_b.in_valid = 1'b0;
            if (cyc == 6) begin e1 = D5; e2 = D6; end
            ea = exp_an(cyc, 3, 0, e1);
            es = exp_seg(cyc, 3, 0, e1, e2);
            ef = (cyc > 0) && (cyc % 6 == 0);
            checks += 3;
            if (bus_b.an !== ea) begin
                errors++;
                $display("FAIL noblank_an cyc=%0d got=%b exp=%b", cyc, bus_b.an, ea);
            end
            if (bus_b.seg_out !== es) begin
                errors++;
                $display("FAIL noblank_seg cyc=%0d got=%b exp=%b", cyc, bus_b.seg_out, es);
            end
            if (bus_b.frame_done !== ef) begin
                errors++;
                $display("FAIL noblank_frame_done cyc=%0d got=%b exp=%b", cyc, bus_b.frame_done, ef);
            end
            step();
        end
    endtask

    // "05" shown from cyc 10, "10" from cyc 20 (tens digit suppressed only
    // when the leading-zero macro is defined).
    task automatic test_leading_zero();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (cyc == 2)  drive_a(1'b1, D0, D5);
            if (cyc == 3)  drive_a(1'b0, '0, '0);
            if (cyc == 12) drive_a(1'b1, D1, D0);
            if (cyc == 13) drive_a(1'b0, '0, '0);
            if (cyc == 10) begin e1 = D0; e2 = D5; end
            if (cyc == 20) begin e1 = D1; e2 = D0; end
            ea = exp_an(cyc, 4, 1, e1);
            es = exp_seg(cyc, 4, 1, e1, e2);
            checks += 2;
            if (bus_a.an !== ea) begin
                errors++;
                $display("FAIL lz_an cyc=%0d got=%b exp=%b", cyc, bus_a.an, ea);
            end
            if (bus_a.seg_out !== es) begin
                errors++;
                $display("FAIL lz_seg cyc=%0d got=%b exp=%b", cyc, bus_a.seg_out, es);
            end
            step();
        end
    endtask

    initial begin
        drive_a(1'b0, '0, '0);
        bus_b.in_valid      = 1'b0;
        bus_b.segmentDigit1 = '0;
        bus_b.segmentDigit2 = '0;
        e1 = '0;
        e2 = '0;

        test_reset();
        test_load();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_blank();
        test_leading_zero();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream stage of the binary-to-7-segment decoder.
- Takes the two decoded digit patterns, `segmentDigit1` (tens) and `segmentDigit2` (ones), both abcdefg with a at the MSB and active-high segments.
- Time-multiplexes both digits onto one shared segment bus with per-digit anode enables and a dead-time blank between digits.
- New patterns enter through a one-entry valid/ready buffer and become visible only at a frame boundary, so a frame never shows a torn value.

Parameters:
- CLK_DIV, 4: cycles each digit is driven per frame; must be >= 1.
- BLANK_CYCLES, 1: dead-time cycles after each digit, with both anodes off; 0 removes the blank states.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- segmentDigit1  input  7  tens pattern from the decoder.
- segmentDigit2  input  7  ones pattern from the decoder.
- in_valid  input  1  the pattern pair on the digit inputs is valid.
- in_ready  output  1  pending buffer empty; the pair is accepted on a cycle where in_valid and in_ready are both high.
- seg_out  output  7  shared segment bus, same bit order as the inputs.
- an  output  2  digit enables, active high; an[1] is tens, an[0] is ones.
- frame_done  output  1  one-cycle pulse at the start of each new frame.

Behaviour:
- Interface clocking: one clock `clk`; `rst` is synchronous and active-high. All state updates on the rising edge of `clk`.
- State machine: SHOW_D1 -> BLANK1 -> SHOW_D2 -> BLANK2 -> SHOW_D1.
  - When BLANK_CYCLES=0: SHOW_D1 -> SHOW_D2 -> SHOW_D1.
- Slot counter `cnt`:
  - Resets to 0 on every state change.
  - A SHOW state lasts exactly CLK_DIV cycles; a BLANK state lasts exactly BLANK_CYCLES cycles.
  - Frame length is 2*(CLK_DIV+BLANK_CYCLES) cycles.
- Outputs are registered and take effect the cycle the state is entered:
  - SHOW_D1: an=2'b10, seg_out=act1.
  - SHOW_D2: an=2'b01, seg_out=act2.
  - BLANK states: an=2'b00, seg_out=7'b0000000.
- Buffering: pending registers pend1/pend2 plus a pend_full flag; in_ready = !pend_full.
  - Accept: pend1/pend2 <= inputs, pend_full <= 1.
  - Frame boundary (the last cycle of BLANK2, or of SHOW_D2 when BLANK_CYCLES=0): if pend_full, then act1/act2 <= pend1/pend2 and pend_full <= 0.
  - No bypass. Data accepted on the boundary cycle itself is stored in pending and is promoted at the following boundary.
  - Accept and promote cannot coincide, because in_ready=0 whenever pend_full=1.
- frame_done:
  - High for exactly the first cycle of each SHOW_D1 entered by a frame wrap.
  - Not asserted in the first SHOW_D1 after reset.
- Reset values:
  - state=SHOW_D1, cnt=0.
  - act1=act2=7'b0000000, pend1=pend2=0, pend_full=0.
  - seg_out=0, an=2'b10, frame_done=0, in_ready=1.
- Reset mid-operation:
  - Aborts the current frame immediately and discards both pending and active data.
  - The display shows blank until new data is loaded and promoted.
- Input patterns are passed through unchanged. Invalid patterns, such as the decoder's 7'b0000000 default, simply display as blank.
- The counter width must hold max(CLK_DIV, BLANK_CYCLES)-1; there is no wrap beyond terminal count.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- With the macro defined: during SHOW_D1, if act1 == 7'b1111110 (digit 0), the block drives an=2'b00 and seg_out=0, suppressing the leading zero. SHOW_D2 is never suppressed.
- Without the macro: act1 is always displayed as received.

Test Plan:
- Reset, CLK_DIV=4, BLANK_CYCLES=1: hold rst 2 cycles, then release.
  - Required: first cycle an=10, seg_out=0000000, in_ready=1, frame_done=0.
  - Required: an sequence 10x4, 00x1, 01x4, 00x1 repeats with period 10; frame_done pulses every 10 cycles starting at the first wrap.
- Load 56: in_valid=1 with d1=1011011, d2=1011111, accepted mid-frame.
  - Required: in_ready drops the next cycle.
  - Required: after the next boundary, SHOW_D1 drives seg_out=1011011 for 4 cycles, SHOW_D2 drives 1011111 for 4 cycles, and in_ready returns to 1.
- Back-pressure: hold in_valid high with pair A, then pair B in the same frame.
  - Required: B is stalled (in_ready=0) until A is promoted at the boundary.
  - Required: B is accepted the cycle after promotion and shown one frame later.
- Reset mid-frame: assert rst during SHOW_D2 with 56 displayed.
  - Required: next cycle state is SHOW_D1, an=10, seg_out=0000000, in_ready=1; 56 is never shown again.
- BLANK_CYCLES=0, CLK_DIV=3:
  - Required: the an sequence alternates 10x3, 01x3 with period 6; an is never 00.
- With SEG_LEADING_ZERO_BLANK_EN defined: load 05 (d1=1111110, d2=1011011).
  - Required: SHOW_D1 drives an=00, seg_out=0; SHOW_D2 drives an=01, seg_out=1011011.
  - Required: loading 10 (d1=0110000) shows d1 normally.
